// File: rtl/spi_sb_if.sv
// ---------------------------------------------------------------------------
// spi_sb_if
// System-bus port of the iCE40 SB_SPI hard IP.
//   sb_stb   : strobe (SBSTBI)        sb_rw    : 1=write, 0=read (SBRWI)
//   sb_adr   : register address       sb_dat_o : write data (SBDATI)
//   sb_dat_i : read data (SBDATO)     sb_ack   : acknowledge (SBACKO)
// The master modport is the sequencer; the slave modport is SB_SPI (or a
// model of it).
// ---------------------------------------------------------------------------
interface spi_sb_if;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dat_o;
  logic [7:0] sb_dat_i;
  logic       sb_ack;

  modport master (
    output sb_stb, sb_rw, sb_adr, sb_dat_o,
    input  sb_dat_i, sb_ack
  );

  modport slave (
    input  sb_stb, sb_rw, sb_adr, sb_dat_o,
    output sb_dat_i, sb_ack
  );
endinterface

// File: rtl/spi_sb_sequencer.sv
// ---------------------------------------------------------------------------
// spi_sb_sequencer
// Runs the iCE40 SB_SPI hard IP as an SPI master over its system bus.
// After reset it programs CR1, CR2, BR and CSR once, then converts a byte
// stream with frame markers into chip-select / TXDR / RXDR transactions.
//
// Ports:
//   clk, rst_n        : clock (also SBCLKI) and asynchronous active-low reset
//   sb                : system bus to SB_SPI (spi_sb_if.master)
//   tx_data/tx_last   : byte to shift out and end-of-frame flag
//   tx_valid/tx_ready : byte handshake (accepted when both are 1)
//   rx_data/rx_valid  : received byte, rx_valid is a one-cycle pulse
//   init_done         : register setup finished
//   busy              : frame in progress
//   error             : sticky bus timeout
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to abort a bus access after
// 255 cycles without acknowledge. Without it the sequencer waits forever
// and error is constant 0.
// ---------------------------------------------------------------------------
module spi_sb_sequencer #(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000,
  parameter logic [5:0] CLK_DIV    = 6'd3,
  parameter logic       CPOL       = 1'b0,
  parameter logic       CPHA       = 1'b0,
  parameter logic [3:0] CS_MASK    = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_sb_if.master   sb,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       init_done,
  output logic       busy,
  output logic       error
);

  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  localparam logic [7:0] CR2_VAL    = {1'b1, 1'b0, 3'b000, CPOL, CPHA, 1'b0};
  localparam logic [7:0] BR_VAL     = {2'b00, CLK_DIV};
  localparam logic [7:0] CS_ON_VAL  = {4'h0, 4'hF & ~CS_MASK};
  localparam logic [7:0] CS_OFF_VAL = 8'h0F;

  typedef enum logic [3:0] {
    INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR,
    IDLE, CS_ON, POLL_TRDY, WR_TX, POLL_RRDY, RD_RX, IN_FRAME, CS_OFF
  } state_t;

  state_t     state_q, state_d;
  logic       stb_q, stb_d;
  logic       rw_q, rw_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       init_done_q, init_done_d;
  logic       busy_q, busy_d;
  logic       accept;

  // Byte latched on acceptance; only meaningful once a byte was taken.
  logic [7:0] byte_q;
  logic       last_q;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       error_q, error_d;
`endif

  // Bus access owned by the current state.
  logic       op_req;
  logic       op_rw;
  logic [3:0] op_reg;
  logic [7:0] op_wdat;

  always_comb begin
    op_req  = 1'b1;
    op_rw   = 1'b1;
    op_reg  = 4'h0;
    op_wdat = 8'h00;
    case (state_q)
      INIT_CR1:  begin op_reg = REG_CR1;  op_wdat = 8'h80;      end
      INIT_CR2:  begin op_reg = REG_CR2;  op_wdat = CR2_VAL;    end
      INIT_BR:   begin op_reg = REG_BR;   op_wdat = BR_VAL;     end
      INIT_CSR:  begin op_reg = REG_CSR;  op_wdat = CS_OFF_VAL; end
      CS_ON:     begin op_reg = REG_CSR;  op_wdat = CS_ON_VAL;  end
      POLL_TRDY: begin op_rw  = 1'b0;     op_reg  = REG_SR;     end
      WR_TX:     begin op_reg = REG_TXDR; op_wdat = byte_q;     end
      POLL_RRDY: begin op_rw  = 1'b0;     op_reg  = REG_SR;     end
      RD_RX:     begin op_rw  = 1'b0;     op_reg  = REG_RXDR;   end
      CS_OFF:    begin op_reg = REG_CSR;  op_wdat = CS_OFF_VAL; end
      default:   op_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    rw_d        = rw_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    accept      = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
    error_d     = error_q;
`endif

    if (op_req) begin
      if (!stb_q) begin
        // Strobe is only raised from a low strobe, so an ack always leaves
        // at least one idle bus cycle before the next access.
        stb_d = 1'b1;
        rw_d  = op_rw;
        adr_d = {BUS_ADDR74, op_reg};
        dat_d = op_wdat;
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_d = 8'd0;
`endif
      end else if (sb.sb_ack) begin
        stb_d = 1'b0;
        case (state_q)
          INIT_CR1:  state_d = INIT_CR2;
          INIT_CR2:  state_d = INIT_BR;
          INIT_BR:   state_d = INIT_CSR;
          INIT_CSR:  state_d = IDLE;
          CS_ON:     state_d = POLL_TRDY;
          POLL_TRDY: if (sb.sb_dat_i[4]) state_d = WR_TX;
          WR_TX:     state_d = POLL_RRDY;
          POLL_RRDY: if (sb.sb_dat_i[3]) state_d = RD_RX;
          RD_RX: begin
            rx_data_d  = sb.sb_dat_i;
            rx_valid_d = 1'b1;
            state_d    = last_q ? CS_OFF : IN_FRAME;
          end
          CS_OFF: begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
          default: state_d = state_q;
        endcase
      end
`ifdef SPI_SEQ_TIMEOUT_EN
      else if (tmo_q == 8'd254) begin
        // 255th strobe cycle without ack: give up and release chip select.
        // A timeout on the release itself goes straight to IDLE.
        stb_d   = 1'b0;
        error_d = 1'b1;
        if (state_q == CS_OFF) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = CS_OFF;
        end
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
`endif
    end else if ((state_q == IDLE || state_q == IN_FRAME) && tx_valid && tx_ready_q) begin
      accept  = 1'b1;
      busy_d  = 1'b1;
      state_d = (state_q == IDLE) ? CS_ON : POLL_TRDY;
    end

    if (state_d == IDLE) init_done_d = 1'b1;
    tx_ready_d = (state_d == IDLE) || (state_d == IN_FRAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_CR1;
      stb_q       <= 1'b0;
      rw_q        <= 1'b0;
      adr_q       <= 8'h00;
      dat_q       <= 8'h00;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q       <= 8'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      rw_q        <= rw_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      error_q     <= error_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      byte_q <= tx_data;
      last_q <= tx_last;
    end
  end

  assign sb.sb_stb   = stb_q;
  assign sb.sb_rw    = rw_q;
  assign sb.sb_adr   = adr_q;
  assign sb.sb_dat_o = dat_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;
`ifdef SPI_SEQ_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_sb_sequencer
// Bench for spi_sb_sequencer with a behavioural SB_SPI model on the system
// bus: configurable ack delay, TRDY stall count, MOSI->MISO loopback through
// TXDR/RXDR, optional spurious ack while the strobe is low and optional
// withheld ack on one register.
// ---------------------------------------------------------------------------
module tb_spi_sb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       init_done;
  logic       busy;
  logic       error;

  spi_sb_if bus();

  spi_sb_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sb        (bus),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .init_done (init_done),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [7:0] adr;
    logic [7:0] dat;
  } txn_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_rx;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // SB_SPI model state and observation counters
  int         ack_delay = 0;
  int         trdy_stall = 0;
  int         trdy_cnt = 0;
  bit         rx_full = 1'b0;
  bit         spur = 1'b0;
  bit         withhold_en = 1'b0;
  logic [3:0] withhold_reg = 4'hD;
  logic [7:0] txd = 8'h00;
  bit         seen = 1'b0;
  bit         acked = 1'b0;
  bit         gap_pending = 1'b0;
  int         cur_len = 0;
  int         min_len = 1000;
  int         max_len = 0;
  int         abort_len = 0;
  int         stable_err = 0;
  int         gap_err = 0;
  int         br_viol = 0;
  logic [16:0] first_t = '0;
  txn_t       log_q[$];
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_full  = 1'b0;
      trdy_cnt = 0;
    end
    if (rx_valid) rx_q.push_back(rx_data);
    if (busy && tx_ready) br_viol++;
    if (gap_pending && bus.sb_stb) gap_err++;
    gap_pending = 1'b0;
    bus.sb_ack  = 1'b0;
    if (bus.sb_stb) begin
      if (!seen) begin
        seen    = 1'b1;
        acked   = 1'b0;
        cur_len = 0;
        first_t = {bus.sb_rw, bus.sb_adr, bus.sb_dat_o};
      end else if ({bus.sb_rw, bus.sb_adr, bus.sb_dat_o} != first_t) begin
        stable_err++;
      end
      cur_len++;
      if (cur_len - 1 >= ack_delay && !acked &&
          !(withhold_en && bus.sb_adr[3:0] == withhold_reg)) begin
        bus.sb_ack  = 1'b1;
        acked       = 1'b1;
        gap_pending = 1'b1;
        log_q.push_back({bus.sb_rw, bus.sb_adr, bus.sb_dat_o});
        if (bus.sb_rw) begin
          if (bus.sb_adr[3:0] == 4'hD) begin
            txd      = bus.sb_dat_o;
            rx_full  = 1'b1;
            trdy_cnt = 0;
          end
        end else begin
          case (bus.sb_adr[3:0])
            4'hC: begin
              bus.sb_dat_i = {3'b000, (trdy_cnt >= trdy_stall), rx_full, 3'b000};
              if (trdy_cnt < trdy_stall) trdy_cnt++;
            end
            4'hE: begin
              bus.sb_dat_i = txd;
              rx_full      = 1'b0;
            end
            default: bus.sb_dat_i = 8'h00;
          endcase
        end
      end
    end else begin
      if (seen) begin
        if (acked) begin
          if (cur_len < min_len) min_len = cur_len;
          if (cur_len > max_len) max_len = cur_len;
        end else begin
          abort_len = cur_len;
        end
        seen = 1'b0;
      end
      bus.sb_ack = spur;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_init(input int bound);
    for (int i = 0; i < bound && !init_done; i++) @(negedge clk);
    check("init_done_wait", {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_ready(input int bound);
    for (int i = 0; i < bound && !tx_ready; i++) @(negedge clk);
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic wait_rx(input int n, input int bound);
    for (int i = 0; i < bound && rx_q.size() < n; i++) @(negedge clk);
    check("rx_count_wait", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && !(tx_ready && !busy); i++) @(negedge clk);
    @(negedge clk);
    check("idle_wait", {30'd0, busy, tx_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    wait_ready(500);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  function automatic int count_w(input logic [7:0] adr, input logic [7:0] dat);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].rw && log_q[i].adr == adr && log_q[i].dat == dat) n++;
    return n;
  endfunction

  function automatic int sr_before_tx();
    int  n = 0;
    bit  found = 1'b0;
    foreach (log_q[i]) begin
      if (!found) begin
        if (log_q[i].rw && log_q[i].adr == 8'h0D) found = 1'b1;
        else if (!log_q[i].rw && log_q[i].adr == 8'h0C) n++;
      end
    end
    return found ? n : -1;
  endfunction

  vec_t        vecs[4];
  logic [15:0] init_tbl[4];
  int          rxc;

  initial begin
    vecs[0] = '{data: 8'hA5, last: 1'b1, exp_rx: 8'hA5};
    vecs[1] = '{data: 8'h01, last: 1'b0, exp_rx: 8'h01};
    vecs[2] = '{data: 8'h02, last: 1'b0, exp_rx: 8'h02};
    vecs[3] = '{data: 8'h03, last: 1'b1, exp_rx: 8'h03};
    init_tbl[0] = 16'h0980;
    init_tbl[1] = 16'h0A80;
    init_tbl[2] = 16'h0B03;
    init_tbl[3] = 16'h0F0F;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stb",      {31'd0, bus.sb_stb}, 32'd0);
    check("rst_rw",       {31'd0, bus.sb_rw},  32'd0);
    check("rst_adr_dat",  {16'd0, bus.sb_adr, bus.sb_dat_o}, 32'd0);
    check("rst_stream",   {22'd0, tx_ready, rx_valid, rx_data}, 32'd0);
    check("rst_status",   {29'd0, init_done, busy, error}, 32'd0);

    // Register setup after reset release
    rst_n = 1'b1;
    @(negedge clk);
    check("first_stb", {31'd0, bus.sb_stb}, 32'd1);
    check("first_adr", bus.sb_adr, 32'h09);
    wait_init(50);
    check("init_txn_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("init_txn%0d", i), log_q[i], {1'b1, init_tbl[i]});
    check("init_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("init_busy", {31'd0, busy}, 32'd0);

    // Frame vectors: one-byte frame, then a three-byte frame
    log_q.delete();
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].data, vecs[i].last);
      wait_rx(i + 1, 300);
      check($sformatf("rx_byte%0d", i), rx_q[i], vecs[i].exp_rx);
      if (vecs[i].last) wait_idle(300);
    end
    check("frame_txn_count", log_q.size(), 20);
    check("single_cs_on",   log_q[0], 17'h10F0E);
    check("single_txdr",    log_q[2], 17'h10DA5);
    check("single_cs_off",  log_q[5], 17'h10F0F);
    check("cs_on_count",  count_w(8'h0F, 8'h0E), 2);
    check("cs_off_count", count_w(8'h0F, 8'h0F), 2);
    check("rx_pulses",    rx_q.size(), 4);

    // TRDY low for five SR reads
    log_q.delete();
    br_viol    = 0;
    trdy_stall = 5;
    send_byte(8'h5A, 1'b1);
    wait_rx(5, 300);
    wait_idle(300);
    trdy_stall = 0;
    check("sr_reads_before_tx", sr_before_tx(), 6);
    check("tx_ready_low_in_frame", br_viol, 0);
    check("rx_after_stall", rx_q[4], 8'h5A);

    // Every access acknowledged after 4 extra cycles
    ack_delay  = 4;
    stable_err = 0;
    gap_err    = 0;
    min_len    = 1000;
    max_len    = 0;
    log_q.delete();
    send_byte(8'h3C, 1'b1);
    wait_rx(6, 500);
    wait_idle(500);
    check("strobe_len_min", min_len, 5);
    check("strobe_len_max", max_len, 5);
    check("bus_stable", stable_err, 0);
    check("bus_gap", gap_err, 0);
    check("rx_delayed_ack", rx_q[5], 8'h3C);
    check("delayed_txn_count", log_q.size(), 6);

    // Ack raised while strobe is low must be ignored
    ack_delay = 0;
    log_q.delete();
    spur = 1'b1;
    repeat (10) @(negedge clk);
    check("spur_no_txn", log_q.size(), 0);
    check("spur_idle", {30'd0, busy, tx_ready}, 32'd1);
    send_byte(8'h96, 1'b1);
    wait_rx(7, 300);
    wait_idle(300);
    spur = 1'b0;
    check("spur_frame_txns", log_q.size(), 6);
    check("spur_rx", rx_q[6], 8'h96);

    // Asynchronous reset while TXDR write is pending
    ack_delay = 20;
    send_byte(8'hC3, 1'b1);
    for (int i = 0; i < 300 && !(bus.sb_stb && bus.sb_adr == 8'h0D); i++) @(negedge clk);
    check("txdr_strobe_seen", {31'd0, bus.sb_stb}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_stb", {31'd0, bus.sb_stb}, 32'd0);
    check("async_rst_status", {29'd0, busy, tx_ready, init_done}, 32'd0);
    @(negedge clk);
    ack_delay = 0;
    rxc = rx_q.size();
    log_q.delete();
    rst_n = 1'b1;
    wait_init(50);
    check("reinit_txn_count", log_q.size(), 4);
    check("reinit_csr", log_q[3], 17'h10F0F);
    check("abort_no_rx", rx_q.size(), rxc);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Ack withheld on the TXDR write
    withhold_en = 1'b1;
    abort_len   = 0;
    rxc         = rx_q.size();
    send_byte(8'h77, 1'b1);
    log_q.delete();
    for (int i = 0; i < 600 && !error; i++) @(negedge clk);
    check("timeout_error", {31'd0, error}, 32'd1);
    wait_idle(100);
    withhold_en = 1'b0;
    check("timeout_strobe_len", abort_len, 255);
    check("timeout_cs_off", log_q[log_q.size() - 1], 17'h10F0F);
    check("timeout_no_rx", rx_q.size(), rxc);
    check("timeout_error_sticky", {31'd0, error}, 32'd1);
`else
    check("error_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
